// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, response FIFO.
// Optional perf counters enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_stage #(
  parameter int unsigned PC_W = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0000_0000_8000_0000),
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc,
  output logic            id_fault
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] last_pc_q, last_pc_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   pwr_q, pwr_d;
  logic [AW-1:0]   prd_q, prd_d;

  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic [PC_W-1:0] pc_mem   [FIFO_DEPTH];
  logic            flt_mem  [FIFO_DEPTH];
  logic [PC_W-1:0] pcq_mem  [FIFO_DEPTH];

  logic            acc;
  logic            push;
  logic            pop;
  logic [CW:0]     used;

  always_comb begin
    used = {1'b0, infl_q} + {1'b0, cnt_q};
    imem_req_valid = (used < DEPTH_L) && !redirect_valid && !rst;
    imem_req_addr = pc_q;
    acc  = imem_req_valid && imem_req_ready;
    push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    id_valid = (cnt_q != '0);
    pop  = id_valid && id_ready && !redirect_valid;
    id_inst  = id_valid ? inst_mem[rd_q] : NOP;
    id_fault = id_valid && flt_mem[rd_q];
    id_pc    = id_valid ? pc_mem[rd_q] : last_pc_q;
  end

  always_comb begin
    pc_d      = pc_q;
    last_pc_d = id_pc;
    infl_d    = infl_q + CW'(acc) - CW'(imem_rsp_valid);
    drop_d    = drop_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    pwr_d     = pwr_q + AW'(acc);
    prd_d     = prd_q + AW'(push);
    if (acc) pc_d = pc_q + PC_W'(4);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~PC_W'(3);
      // inflight already counts requests that are pending a drop
      drop_d = infl_q - CW'(imem_rsp_valid);
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      pwr_d  = '0;
      prd_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      last_pc_q <= '0;
      infl_q    <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      pwr_q     <= '0;
      prd_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      infl_q    <= infl_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      pwr_q     <= pwr_d;
      prd_q     <= prd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= imem_rsp_err ? NOP : imem_rsp_data;
      pc_mem[wr_q]   <= pcq_mem[prd_q];
      flt_mem[wr_q]  <= imem_rsp_err;
    end
    if (acc) pcq_mem[pwr_q] <= pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (cnt_q == CW'(FIFO_DEPTH))));
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 64'(pop);
    stall_cnt_d = stall_cnt_q
                + 64'(id_ready && !id_valid && !redirect_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with an epoch-tagged memory model
// and a scoreboard of expected decode-side entries.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        id_fault;
`ifdef IFETCH_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ifetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_fault       (id_fault)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] ep;
  } mreq_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        flt;
  } ent_t;

  mreq_t       mem_q [$];
  ent_t        exp_q [$];
  logic [63:0] acc_log [$];
  logic [63:0] pop_pc [$];
  logic [31:0] pop_inst [$];
  logic        pop_flt [$];

  int tests = 0;
  int fails = 0;
  logic [31:0] epoch = 0;

  logic        mem_ready = 0;
  logic        id_rdy = 0;
  logic        redir = 0;
  logic [63:0] redir_pc = 0;
  logic        hold = 0;
  logic        err_en = 0;
  logic [63:0] err_addr = 0;

  logic        s_req, s_idv, s_idflt;
  logic [63:0] s_addr, s_idpc;
  logic [31:0] s_idinst;

  function automatic logic [31:0] memdata(input logic [63:0] a);
    return a[31:0] * 32'd3 + 32'h0bad_0001;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    mreq_t r;
    ent_t e;
    logic [31:0] d;
    logic er;
    logic have;
    have = 1'b0;
    d = '0;
    er = 1'b0;
    r = '0;
    @(negedge clk);
    imem_req_ready = mem_ready;
    id_ready = id_rdy;
    redirect_valid = redir;
    redirect_pc = redir_pc;
    if (!hold && mem_q.size() > 0) begin
      r = mem_q.pop_front();
      d = memdata(r.addr);
      er = err_en && (r.addr == err_addr);
      have = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = d;
      imem_rsp_err = er;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'hdead_beef;
      imem_rsp_err = 1'b0;
    end
    #1;
    s_req = imem_req_valid;
    s_addr = imem_req_addr;
    s_idv = id_valid;
    s_idpc = id_pc;
    s_idinst = id_inst;
    s_idflt = id_fault;
    chk("sb_valid", s_idv, exp_q.size() != 0);
    if (s_idv && id_rdy && !redir && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pc", s_idpc, e.pc);
      chk("sb_inst", s_idinst, e.inst);
      chk("sb_fault", s_idflt, e.flt);
      pop_pc.push_back(s_idpc);
      pop_inst.push_back(s_idinst);
      pop_flt.push_back(s_idflt);
    end
    if (have && r.ep == epoch && !redir)
      exp_q.push_back({r.addr, er ? NOP : d, er});
    if (s_req && mem_ready) begin
      mem_q.push_back({s_addr, epoch});
      acc_log.push_back(s_addr);
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    imem_rsp_err = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    mem_ready = 0;
    id_rdy = 0;
    redir = 0;
    hold = 0;
    #1;
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_id_valid"}, id_valid, 0);
    chk({tag, "_id_inst"}, id_inst, NOP);
    chk({tag, "_id_pc"}, id_pc, 0);
    chk({tag, "_id_fault"}, id_fault, 0);
`ifdef IFETCH_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 0);
    chk({tag, "_perf_stall"}, perf_stall_cnt, 0);
`endif
    mem_q.delete();
    exp_q.delete();
    acc_log.delete();
    pop_pc.delete();
    pop_inst.delete();
    pop_flt.delete();
    epoch++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    mem_ready = 0;
    id_rdy = 1;
    hold = 0;
    redir = 0;
    for (int k = 0; k < 30 && (mem_q.size() > 0 || exp_q.size() > 0); k++)
      cyc();
    cyc();
    chk(tag, mem_q.size() + exp_q.size(), 0);
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int k = 0; k < 30 && acc_log.size() < n; k++) cyc();
    chk(tag, acc_log.size() >= n, 1);
  endtask

  task automatic wait_idv(input string tag);
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (s_idv) break;
    end
    chk(tag, s_idv, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset("rst0");

    // in-order fetch, 1-cycle memory, decode always ready
    mem_ready = 1;
    id_rdy = 1;
    cyc();
    chk("t1_first_req", s_req, 1);
    chk("t1_first_addr", s_addr, RPC);
    chk("t1_idv_c0", s_idv, 0);
    cyc();
    chk("t1_idv_c1", s_idv, 0);
    cyc();
    chk("t1_idv_c2", s_idv, 1);
    chk("t1_idpc_c2", s_idpc, RPC);
    wait_acc(3, "t1_acc_timeout");
    chk("t1_addr1", acc_log.size() > 1 ? acc_log[1] : 'x, RPC + 4);
    chk("t1_addr2", acc_log.size() > 2 ? acc_log[2] : 'x, RPC + 8);
    drain("t1_drain");

    // decode back-pressure
    do_reset("rst1");
    mem_ready = 1;
    id_rdy = 0;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_req_stall", s_req, 0);
      chk("t2_idv_hold", s_idv, 1);
      chk("t2_idpc_hold", s_idpc, RPC);
      chk("t2_inst_hold", s_idinst, memdata(RPC));
    end
    id_rdy = 1;
    cyc();
    chk("t2_pop0", s_idpc, RPC);
    cyc();
    chk("t2_pop1_v", s_idv, 1);
    chk("t2_pop1", s_idpc, RPC + 4);
    drain("t2_drain");

    // redirect with two fetches in flight
    hold = 1;
    mem_ready = 1;
    id_rdy = 1;
    acc_log.delete();
    cyc();
    cyc();
    chk("t3_two_inflight", acc_log.size(), 2);
    redir = 1;
    redir_pc = 64'h0000_0000_8000_0103;
    cyc();
    chk("t3_no_req_redir", s_req, 0);
    redir = 0;
    hold = 0;
    acc_log.delete();
    wait_acc(1, "t3_acc_timeout");
    chk("t3_new_addr", acc_log.size() > 0 ? acc_log[0] : 'x,
        64'h0000_0000_8000_0100);
    wait_idv("t3_idv_timeout");
    chk("t3_first_pc", s_idpc, 64'h0000_0000_8000_0100);
    drain("t3_drain");

    // redirect coinciding with a response and a pop
    mem_ready = 1;
    id_rdy = 0;
    cyc();
    cyc();
    mem_ready = 0;
    id_rdy = 1;
    redir = 1;
    redir_pc = 64'h0000_0000_8000_0200;
    cyc();
    chk("t4_pre_idv", s_idv, 1);
    redir = 0;
    mem_ready = 1;
    cyc();
    chk("t4_empty", s_idv, 0);
    wait_idv("t4_idv_timeout");
    chk("t4_pc", s_idpc, 64'h0000_0000_8000_0200);
    drain("t4_drain");

    // access fault on the third fetch
    do_reset("rst2");
    err_en = 1;
    err_addr = RPC + 8;
    mem_ready = 1;
    id_rdy = 1;
    for (int k = 0; k < 30 && pop_pc.size() < 4; k++) cyc();
    chk("t5_pop_cnt", pop_pc.size() >= 4, 1);
    chk("t5_err_pc", pop_pc.size() > 2 ? pop_pc[2] : 'x, RPC + 8);
    chk("t5_err_inst", pop_inst.size() > 2 ? pop_inst[2] : 'x, NOP);
    chk("t5_err_flt", pop_flt.size() > 2 ? pop_flt[2] : 'x, 1);
    chk("t5_next_flt", pop_flt.size() > 3 ? pop_flt[3] : 'x, 0);
    chk("t5_next_pc", pop_pc.size() > 3 ? pop_pc[3] : 'x, RPC + 12);
    err_en = 0;
    drain("t5_drain");

    // reset with one buffered entry
    mem_ready = 1;
    id_rdy = 0;
    cyc();
    mem_ready = 0;
    cyc();
    cyc();
    chk("t6_one_entry", s_idv, 1);
    do_reset("t6_rst");
    mem_ready = 1;
    id_rdy = 1;
    wait_acc(1, "t6_acc_timeout");
    chk("t6_first_addr", acc_log.size() > 0 ? acc_log[0] : 'x, RPC);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
